bcd_to_binary: RTL and testbench
================================

# bcd_to_binary

Sequential converter from packed BCD to unsigned binary using reverse double dabble (shift right, subtract 3). Typical use is turning decimal values into binary, such as thresholds entered on switches or scores held in BCD, for arithmetic. It is the inverse companion of the binary-to-BCD display converter and uses the same START/idle style. It adds BUSY/DONE handshake outputs and an optional invalid-digit check.

## Interface
- DIGITS, 4, number of packed BCD digits at the input.
- BIN_W, 14, output width. Must satisfy 2^BIN_W > 10^DIGITS − 1; the default covers 9999.
- CLK  input  1  system clock, 100 MHz.
- RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
- START  input  1  requests a conversion. Sampled only in Idle.
- BCDIN  input  4*DIGITS  packed BCD. [3:0] is the ones digit and the most significant nibble is the top digit. Captured on the edge that accepts START.
- BINOUT  output  BIN_W  last converted result. Holds its value between conversions.
- BUSY  output  1  high while the state is not Idle.
- DONE  output  1  one-cycle pulse when BINOUT updates or when a conversion ends in error.
- ERR  output  1  invalid-digit flag. Tied to 0 unless BCD_TO_BINARY_CHECK_EN is defined.

## Operation
- Shift register `sr` is {bcd field of 4*DIGITS bits, bin field of 4*DIGITS bits}. Shift counter width is clog2(4*DIGITS+1).
- The state machine has five states: Idle, Init, Shift, Check, Done.
  - Idle: if START=1, load `sr` ← {BCDIN, 0}, clear ERR, go to Init. Otherwise stay in Idle.
  - Init: clear the shift count. With the check macro, go to Done on an invalid digit. Otherwise go to Shift.
  - Shift: `sr` ← `sr` >> 1 with a zero filled into the MSB. Increment the count. Go to Check.
  - Check: for every bcd-field nibble, if the nibble is ≥ 8, subtract 3 (4-bit arithmetic, no carry between nibbles). All nibbles are corrected in parallel. If count = 4*DIGITS go to Done, otherwise go to Shift.
  - Done: BINOUT ← low BIN_W bits of the bin field. Pulse DONE. Go to Idle.
- Arithmetic: the result equals the decimal value of BCDIN. Bits of the bin field above BIN_W are discarded; with legal parameters they are 0.
- START is ignored whenever BUSY=1. If START is held high, a new conversion is accepted on the first edge after Done.
- RST, including mid-conversion: state → Idle; BINOUT=0, BUSY=0, DONE=0, ERR=0; `sr` and count are cleared. An aborted conversion produces no DONE.

## Timing
- Reset values: every output is 0.
- E0 is the edge that accepts START.
  - Init executes at E1.
  - Shift k executes at E(2k) and Check k at E(2k+1).
  - Done executes at E(8*DIGITS+2), which is E34 for the default.
- BINOUT and DONE change at E(8*DIGITS+2). DONE drops one edge later.
- BUSY rises at E0 and falls at E(8*DIGITS+2), the same edge on which DONE rises.
- BCDIN need only be stable at E0.
- The earliest next START acceptance is E(8*DIGITS+3).

## Configuration
- BCD_TO_BINARY_CHECK_EN defined:
  - Init tests every BCDIN nibble for a value > 9.
  - On failure, go to Done. At E2: ERR=1, DONE pulses, BINOUT is unchanged.
  - ERR stays high until the next accepted START.
- BCD_TO_BINARY_CHECK_EN undefined:
  - No check is made and ERR is constant 0.
  - Illegal nibbles convert without error; the output is the raw algorithm result (not specified as a meaningful value), and timing is unchanged.

## Structure
- Package `bcd_conv_pkg` holds:
  - the state encoding constants for Idle, Init, Shift, Check and Done;
  - the default DIGITS and BIN_W values;
  - the BCD_DIGIT_MAX (9) and CORRECT_THRESH (8) constants.
- One sub-module, `bcd_nibble_sub3`: 4-bit combinational corrector (≥ 8 → −3), instantiated DIGITS times with a generate loop and used in the Check state.

## Test plan
- Apply RST for 2 cycles with START low → all outputs 0; BUSY stays low for 10 further cycles.
- BCDIN=16'h9999 with START pulsed at E0 → BINOUT=14'd9999 and DONE high for exactly one cycle at E34. BUSY is high over E0–E33.
- Back-to-back conversions with START held high:
  - 16'h0000 then 16'h1023 gives BINOUT 0, then 1023.
  - DONE spacing is 35 cycles.
- START during BUSY:
  - Inputs: BCDIN=16'h0042, START pulsed at E0. At E10, START pulses again with BCDIN=16'h0777.
  - Expected: BINOUT=42 at E34 and no second DONE.
- RST asserted at E12 of the 16'h0500 conversion → no DONE, BINOUT=0. A new 16'h0500 conversion then returns 500.
- With BCD_TO_BINARY_CHECK_EN, after a prior result of 7:
  - BCDIN=16'h12A4 → ERR=1 and DONE at E2, BINOUT stays 7.
  - The next valid START clears ERR at its E0.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t        : converter FSM states (Idle, Init, Shift, Check, Done)
//   DEF_DIGITS     : default number of packed BCD digits
//   DEF_BIN_W      : default binary output width (covers 9999)
//   BCD_DIGIT_MAX  : largest legal BCD digit value
//   CORRECT_THRESH : nibble value at and above which 3 is subtracted
package bcd_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_DIGITS     = 4;
  localparam int DEF_BIN_W      = 14;
  localparam int BCD_DIGIT_MAX  = 9;
  localparam int CORRECT_THRESH = 8;

endpackage

// File: rtl/bcd_nibble_sub3.sv
// Combinational per-digit corrector for reverse double dabble.
// After a right shift a BCD nibble that reads 8 or more has received a
// half-ten (weight 8 instead of 5), so 3 is removed to restore it.
// Ports:
//   din  : nibble as it sits after the shift
//   dout : corrected nibble (din - 3 when din >= 8, else din)
module bcd_nibble_sub3
  import bcd_conv_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'(CORRECT_THRESH)) begin
      dout = din - 4'd3;
    end
  end

endmodule

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to unsigned binary converter (reverse double dabble).
// One conversion takes 8*DIGITS+2 edges from START acceptance to DONE.
// Ports:
//   CLK    : system clock
//   RST    : synchronous active-high reset
//   START  : conversion request, sampled only while idle
//   BCDIN  : packed BCD input, [3:0] = ones digit, captured on acceptance
//   BINOUT : last converted result, held between conversions
//   BUSY   : high while the FSM is not idle
//   DONE   : one-cycle pulse on result update or error termination
//   ERR    : invalid-digit flag
// Optional feature macro: BCD_TO_BINARY_CHECK_EN enables the invalid-digit
// check; when undefined ERR is constant 0 and illegal digits convert anyway.
module bcd_to_binary
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [4*DIGITS-1:0]   BCDIN,
  output logic [BIN_W-1:0]      BINOUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int FW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(FW + 1);

  state_t            state, state_nxt;
  logic [2*FW-1:0]   sr;
  logic [CNT_W-1:0]  cnt;
  logic [FW-1:0]     bcd_fix;
  logic              cnt_last;
  logic              done_r;

  // Upper half of sr is the BCD field, lower half collects the binary result.
  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    bcd_nibble_sub3 u_fix (
      .din  (sr[FW + 4*g +: 4]),
      .dout (bcd_fix[4*g +: 4])
    );
  end

  assign cnt_last = (cnt == CNT_W'(FW));

`ifdef BCD_TO_BINARY_CHECK_EN
  logic bad_digit;
  logic bad_flag;
  logic err_r;

  // The captured copy in sr is tested so BCDIN only needs to be stable at E0.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[FW + 4*i +: 4] > 4'(BCD_DIGIT_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign ERR = err_r;
`else
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (START) state_nxt = ST_INIT;
`ifdef BCD_TO_BINARY_CHECK_EN
      ST_INIT:  state_nxt = bad_digit ? ST_DONE : ST_SHIFT;
`else
      ST_INIT:  state_nxt = ST_SHIFT;
`endif
      ST_SHIFT: state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = cnt_last ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr     <= '0;
      cnt    <= '0;
      BINOUT <= '0;
      done_r <= 1'b0;
`ifdef BCD_TO_BINARY_CHECK_EN
      bad_flag <= 1'b0;
      err_r    <= 1'b0;
`endif
    end else begin
      // DONE is registered from the Done state, so it pulses for exactly one
      // cycle after the edge that executes Done.
      done_r <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (START) begin
            sr <= {BCDIN, {FW{1'b0}}};
`ifdef BCD_TO_BINARY_CHECK_EN
            err_r    <= 1'b0;
            bad_flag <= 1'b0;
`endif
          end
        end
        ST_INIT: begin
          cnt <= '0;
`ifdef BCD_TO_BINARY_CHECK_EN
          bad_flag <= bad_digit;
`endif
        end
        ST_SHIFT: begin
          sr  <= sr >> 1;
          cnt <= cnt + 1'b1;
        end
        ST_CHECK: begin
          sr[2*FW-1:FW] <= bcd_fix;
        end
        ST_DONE: begin
`ifdef BCD_TO_BINARY_CHECK_EN
          if (bad_flag) begin
            err_r <= 1'b1;
          end else begin
            BINOUT <= sr[BIN_W-1:0];
          end
`else
          BINOUT <= sr[BIN_W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state != ST_IDLE);
  assign DONE = done_r;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary (DIGITS=4, BIN_W=14).
module tb_bcd_to_binary;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [15:0] BCDIN;
  logic [13:0] BINOUT;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int checks   = 0;
  int failures = 0;

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .BCDIN  (BCDIN),
    .BINOUT (BINOUT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decimal value of a packed BCD word.
  function automatic int ref_val(input logic [15:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives START for one edge (E0); returns 1 time unit after E0.
  task automatic start_conv(input logic [15:0] v);
    BCDIN = v;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Counts edges until DONE is seen; lat is the edge index relative to E0.
  task automatic wait_done(input int first, output int lat, output int busy_bad);
    lat = first;
    busy_bad = 0;
    while (lat < 200) begin
      tick();
      lat++;
      if (DONE) break;
      if (!BUSY) busy_bad++;
    end
    if (lat >= 200) chk("done_timeout", 32'(lat), 32'd34);
  endtask

  task automatic run_conv(input string tag, input logic [15:0] v, input bit check_val);
    int lat, bb;
    start_conv(v);
    chk({tag, "_busy_rise"}, 32'(BUSY), 32'd1);
    wait_done(0, lat, bb);
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk({tag, "_busy_during"}, 32'(bb), 32'd0);
    chk({tag, "_busy_fall"}, 32'(BUSY), 32'd0);
    if (check_val) chk({tag, "_value"}, 32'(BINOUT), 32'(ref_val(v)));
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    tick();
    chk({tag, "_done_drop"}, 32'(DONE), 32'd0);
  endtask

  initial begin
    int lat, bb, cnt_bad;
    logic [15:0] v;
    logic [15:0] prev;

    RST   = 1'b1;
    START = 1'b0;
    BCDIN = '0;

    // Reset state
    repeat (2) tick();
    chk("rst_binout", 32'(BINOUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    cnt_bad = 0;
    repeat (10) begin
      tick();
      if (BUSY || DONE) cnt_bad++;
    end
    chk("idle_quiet", 32'(cnt_bad), 32'd0);

    // Largest value
    run_conv("max", 16'h9999, 1'b1);

    // Back-to-back with START held high
    BCDIN = 16'h0000;
    START = 1'b1;
    tick();
    BCDIN = 16'h1023;
    wait_done(0, lat, bb);
    chk("b2b_first_lat", 32'(lat), 32'd34);
    chk("b2b_first_val", 32'(BINOUT), 32'd0);
    wait_done(0, lat, bb);
    START = 1'b0;
    chk("b2b_spacing", 32'(lat), 32'd35);
    chk("b2b_second_val", 32'(BINOUT), 32'd1023);
    tick();
    chk("b2b_done_drop", 32'(DONE), 32'd0);
    repeat (3) tick();
    chk("b2b_idle", 32'(BUSY), 32'd0);

    // START while busy is ignored
    start_conv(16'h0042);
    repeat (9) tick();
    BCDIN = 16'h0777;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(10, lat, bb);
    chk("busy_start_lat", 32'(lat), 32'd34);
    chk("busy_start_val", 32'(BINOUT), 32'd42);
    cnt_bad = 0;
    repeat (40) begin
      tick();
      if (DONE || BUSY) cnt_bad++;
    end
    chk("busy_start_no_second", 32'(cnt_bad), 32'd0);

    // Reset mid-conversion at E12
    start_conv(16'h0500);
    repeat (11) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_binout", 32'(BINOUT), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    cnt_bad = 0;
    repeat (40) begin
      tick();
      if (DONE || BUSY) cnt_bad++;
    end
    chk("abort_no_done", 32'(cnt_bad), 32'd0);
    run_conv("after_abort", 16'h0500, 1'b1);

    // Randomized legal BCD values
    for (int n = 0; n < 12; n++) begin
      v = '0;
      for (int d = 0; d < 4; d++) v[4*d +: 4] = 4'($urandom_range(9, 0));
      run_conv("rand", v, 1'b1);
    end

`ifdef BCD_TO_BINARY_CHECK_EN
    run_conv("pre_err", 16'h0007, 1'b1);
    start_conv(16'h12A4);
    wait_done(0, lat, bb);
    chk("err_latency", 32'(lat), 32'd2);
    chk("err_flag", 32'(ERR), 32'd1);
    chk("err_binout_held", 32'(BINOUT), 32'd7);
    repeat (5) tick();
    chk("err_sticky", 32'(ERR), 32'd1);
    chk("err_done_low", 32'(DONE), 32'd0);
    start_conv(16'h0005);
    chk("err_cleared", 32'(ERR), 32'd0);
    wait_done(0, lat, bb);
    chk("err_next_val", 32'(BINOUT), 32'd5);
    tick();
`else
    // Illegal digits: timing unchanged, no error reported
    prev = 16'h12A4;
    start_conv(prev);
    wait_done(0, lat, bb);
    chk("illegal_latency", 32'(lat), 32'd34);
    chk("illegal_err", 32'(ERR), 32'd0);
    tick();
    run_conv("after_illegal", 16'h0314, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
